// File: rtl/mult_div_unit_pkg.sv
// Shared md_c opcode encodings and small arithmetic helpers for the E-stage
// multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MULTU_A = 4'd0,
        MULT_A  = 4'd1,
        DIVU_A  = 4'd2,
        DIV_A   = 4'd3,
        MTHI_A  = 4'd4,
        MTLO_A  = 4'd5
    } md_op_e;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: holds HI/LO, runs mult/div with a fixed busy
// period and commits the pending result when the down-counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_s,
    input  logic [3:0]  md_c,
    input  logic        m_md,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        start_busy,
    output logic [31:0] hilo_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [31:0]      hi, lo;
    logic [31:0]      p_hi, p_lo;

    logic        is_mult, is_div, is_signed;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b, q_mag, r_mag;
    logic [31:0] quotient, remainder;
    logic [63:0] product;

    always_comb begin
        is_mult   = (md_c == MULT_A) || (md_c == MULTU_A);
        is_div    = (md_c == DIV_A)  || (md_c == DIVU_A);
        is_signed = (md_c == MULT_A) || (md_c == DIV_A);
        sign_a    = is_signed & a[31];
        sign_b    = is_signed & b[31];
        product   = {{32{sign_a}}, a} * {{32{sign_b}}, b};
        // Divide magnitudes unsigned so 0x80000000 / -1 cannot overflow.
        mag_a     = neg_if(sign_a, a);
        mag_b     = neg_if(sign_b, b);
        q_mag     = (mag_b == '0) ? '0 : mag_a / mag_b;
        r_mag     = (mag_b == '0) ? '0 : mag_a % mag_b;
        quotient  = neg_if(sign_a ^ sign_b, q_mag);
        remainder = neg_if(sign_a, r_mag);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi    <= '0;
            lo    <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (busy) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                hi   <= p_hi;
                lo   <= p_lo;
                busy <= 1'b0;
            end
        end else if (md_s && is_mult) begin
            {p_hi, p_lo} <= product;
            count        <= CNT_W'(MULT_CYCLES);
            busy         <= 1'b1;
        end else if (md_s && is_div) begin
            // Divide by zero re-commits the current HI/LO, leaving them unchanged.
            {p_hi, p_lo} <= (b == '0) ? {hi, lo} : {remainder, quotient};
            count        <= CNT_W'(DIV_CYCLES);
            busy         <= 1'b1;
        end else if (!md_s && md_c == MTHI_A) begin
            hi <= a;
        end else if (!md_s && md_c == MTLO_A) begin
            lo <= a;
        end
    end

    assign start_busy = md_s | busy;
    assign hilo_out   = m_md ? lo : hi;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences and randomized operations against a 64-bit arithmetic model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        md_s = 1'b0;
    logic [3:0]  md_c = 4'd0;
    logic        m_md = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, start_busy;
    logic [31:0] hilo_out;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_s(md_s), .md_c(md_c), .m_md(m_md),
        .a(a), .b(b), .busy(busy), .start_busy(start_busy), .hilo_out(hilo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_hilo(input string tag);
        m_md = 1'b0;
        #1 check({tag, " hi"}, hilo_out, m_hi);
        m_md = 1'b1;
        #1 check({tag, " lo"}, hilo_out, m_lo);
        m_md = 1'b0;
    endtask

    function automatic logic [63:0] ref_model(input md_op_e op, input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] h, input logic [31:0] l);
        longint          sq, sr;
        longint unsigned uq, ur;
        case (op)
            MULT_A:  return 64'(longint'($signed(x)) * longint'($signed(y)));
            MULTU_A: return 64'({32'd0, x} * {32'd0, y});
            DIV_A: begin
                if (y == 0) return {h, l};
                sq = longint'($signed(x)) / longint'($signed(y));
                sr = longint'($signed(x)) % longint'($signed(y));
                return {sr[31:0], sq[31:0]};
            end
            DIVU_A: begin
                if (y == 0) return {h, l};
                uq = {32'd0, x} / {32'd0, y};
                ur = {32'd0, x} % {32'd0, y};
                return {ur[31:0], uq[31:0]};
            end
            default: return {h, l};
        endcase
    endfunction

    task automatic run_op(input md_op_e op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit interfere, input string tag);
        int n;
        int exp_n;
        exp_n = (op == MULT_A || op == MULTU_A) ? 5 : 10;
        @(negedge clk);
        md_c = op; a = x; b = y; md_s = 1'b1;
        #1 check({tag, " start_busy"}, 32'(start_busy), 32'd1);
        @(negedge clk);
        md_s = 1'b0; md_c = MULTU_A;
        check_hilo({tag, " old"});
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            a = $urandom; b = $urandom;
            if (interfere && n == 2) begin
                md_s = 1'b1; md_c = MULT_A;
            end else if (interfere && n == 3) begin
                md_s = 1'b0; md_c = MTHI_A;
            end else begin
                md_s = 1'b0; md_c = MULTU_A;
            end
            @(negedge clk);
        end
        md_s = 1'b0; md_c = MULTU_A;
        check({tag, " busy cycles"}, 32'(n), 32'(exp_n));
        m_hi = exp_hi;
        m_lo = exp_lo;
        check_hilo(tag);
    endtask

    task automatic move_to(input md_op_e op, input logic [31:0] x, input string tag);
        @(negedge clk);
        md_c = op; a = x; md_s = 1'b0;
        @(negedge clk);
        md_c = MULTU_A; a = $urandom;
        if (op == MTHI_A) m_hi = x;
        else m_lo = x;
        #1 check({tag, " busy"}, 32'(busy), 32'd0);
        check_hilo(tag);
    endtask

    initial begin
        logic [63:0] r;
        md_op_e      op;
        logic [31:0] x, y;

        tbl[0] = '{MULT_A,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1] = '{MULTU_A, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{DIV_A,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{DIVU_A,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        tbl[4] = '{DIV_A,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5] = '{MULT_A,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[6] = '{MULTU_A, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        tbl[7] = '{DIV_A,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[8] = '{DIVU_A,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset start_busy", 32'(start_busy), 32'd0);
        check_hilo("reset");
        #11 reset = 1'b1;

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b0, $sformatf("vec%0d", i));

        move_to(MTHI_A, 32'h12345678, "mthi");
        move_to(MTHI_A, 32'h0000000A, "mthi A");
        move_to(MTLO_A, 32'h0000000B, "mtlo B");
        run_op(DIV_A, 32'h00000005, 32'h00000000, 32'h0000000A, 32'h0000000B, 1'b1, "div0");
        run_op(DIVU_A, 32'h00000009, 32'h00000000, 32'h0000000A, 32'h0000000B, 1'b0, "divu0");

        for (int i = 0; i < 40; i++) begin
            op = md_op_e'($urandom_range(0, 5));
            x  = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 9);
                2:       y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            if (op == MTHI_A || op == MTLO_A) begin
                move_to(op, x, $sformatf("rnd%0d mt", i));
            end else begin
                r = ref_model(op, x, y, m_hi, m_lo);
                run_op(op, x, y, r[63:32], r[31:0], 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            end
        end

        @(negedge clk);
        md_c = DIV_A; a = 32'd100; b = 32'd7; md_s = 1'b1;
        @(negedge clk);
        md_s = 1'b0; md_c = MULTU_A;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1 check("async reset busy", 32'(busy), 32'd0);
        check_hilo("async reset");
        #1 reset = 1'b1;
        repeat (15) @(negedge clk);
        check("post reset busy", 32'(busy), 32'd0);
        check_hilo("post reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
